// File: rtl/pong_pos_regfile.sv
// iomem slave: CPU-written shadow positions committed to the renderer at vsync fall, plus buttons and frame counter.
// Optional macro PONG_BTN_DEBOUNCE_EN debounces each button over DEBOUNCE_CYCLES stable cycles.
module pong_pos_regfile #(
    parameter int PADDLE_INIT     = 150,
    parameter int BALL_INIT_X     = 320,
    parameter int BALL_INIT_Y     = 240,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        vsync,
    input  logic [3:0]  btn,
    output logic [9:0]  paddle_left_pos,
    output logic [9:0]  paddle_right_pos,
    output logic [9:0]  ball_pos_x,
    output logic [9:0]  ball_pos_y,
    output logic        frame_tick
);
    // Index 0..3 = left, right, ball x, ball y, matching addr[25:24] of pages 0x04..0x07.
    localparam logic [3:0][9:0] POS_INIT =
        {10'(BALL_INIT_Y), 10'(BALL_INIT_X), 10'(PADDLE_INIT), 10'(PADDLE_INIT)};

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [7:0]      page;
    logic [1:0]      sel;
    logic            is_pos, is_btn, is_stat, acc, wr_pos, rd_btn, fall;
    logic            ready_q;
    logic [31:0]     rdata_q, rdata_d;
    logic [3:0][9:0] sh_q, sh_d, act_q;
    logic            pending_q, vsync_q, tick_q;
    logic [15:0]     fcnt_q;
    logic [3:0]      sync1_q, sync2_q, level, rise, sticky_q, sticky_d;
    logic            unused_bits;

    assign page    = iomem_addr[31:24];
    assign sel     = iomem_addr[25:24];
    assign is_pos  = (page[7:2] == 6'b000001);
    assign is_btn  = (page[7:2] == 6'b000010);
    assign is_stat = (page == 8'h0C);
    // Unclaimed pages never acknowledge so another slave may answer.
    assign acc     = iomem_valid & ~ready_q & (is_pos | is_btn | is_stat);
    assign wr_pos  = acc & is_pos & (|iomem_wstrb[1:0]);
    assign rd_btn  = acc & is_btn & (iomem_wstrb == 4'd0);
    assign fall    = vsync_q & ~vsync;

    assign unused_bits = ^{iomem_addr[23:0], iomem_wdata[31:10], iomem_wstrb[3:2]};

    always_comb begin
        rdata_d = '0;
        if (acc) begin
            if (is_pos)      rdata_d = {22'd0, sh_q[sel]};
            else if (is_btn) rdata_d = {30'd0, sticky_q[sel], level[sel]};
            else             rdata_d = {fcnt_q, 15'd0, pending_q};
        end
    end

    always_comb begin
        sh_d = sh_q;
        if (wr_pos) begin
            if (iomem_wstrb[0]) sh_d[sel][7:0] = iomem_wdata[7:0];
            if (iomem_wstrb[1]) sh_d[sel][9:8] = iomem_wdata[9:8];
        end
    end

    // A read clears first, a same-cycle press sets afterwards, so the press survives.
    always_comb begin
        sticky_d = sticky_q;
        if (rd_btn) sticky_d[sel] = 1'b0;
        sticky_d = sticky_d | rise;
    end

`ifdef PONG_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < 4; i++) begin : g_deb
        logic [CW-1:0] cnt_q;
        logic          lvl_q, hit;

        assign hit      = (sync2_q[i] != lvl_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        assign rise[i]  = hit & ~lvl_q;
        assign level[i] = lvl_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                if ((sync2_q[i] == lvl_q) || hit) cnt_q <= '0;
                else                              cnt_q <= cnt_q + CW'(1);
                lvl_q <= lvl_q ^ hit;
            end
        end
    end
`else
    // rise anticipates the level edge so sticky and level flip on the same clock.
    assign level = sync2_q;
    assign rise  = sync1_q & ~sync2_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            sh_q      <= POS_INIT;
            act_q     <= POS_INIT;
            pending_q <= 1'b0;
            vsync_q   <= 1'b0;
            tick_q    <= 1'b0;
            fcnt_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sticky_q  <= '0;
        end else begin
            ready_q   <= acc;
            rdata_q   <= rdata_d;
            sh_q      <= sh_d;
            if (fall && pending_q) act_q <= sh_q;
            pending_q <= wr_pos | (pending_q & ~fall);
            vsync_q   <= vsync;
            tick_q    <= fall;
            if (fall) fcnt_q <= fcnt_q + 16'd1;
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            sticky_q  <= sticky_d;
        end
    end

    assign iomem_ready      = ready_q;
    assign iomem_rdata      = rdata_q;
    assign paddle_left_pos  = act_q[0];
    assign paddle_right_pos = act_q[1];
    assign ball_pos_x       = act_q[2];
    assign ball_pos_y       = act_q[3];
    assign frame_tick       = tick_q;
endmodule

// File: tb/tb_pong_pos_regfile.sv
// Self-checking bench for pong_pos_regfile: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pong_pos_regfile;
    localparam int DB = 8;
`ifdef PONG_BTN_DEBOUNCE_EN
    localparam int BTN_WAIT = DB + 4;
`else
    localparam int BTN_WAIT = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        vsync;
    logic [3:0]  btn;
    logic [9:0]  paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y;
    logic        frame_tick;

    int cmp = 0;
    int errs = 0;

    // Behavioural model state
    logic [9:0]  m_sh [4];
    logic [9:0]  m_act [4];
    logic        m_pend;
    logic [15:0] m_fc;
    logic [3:0]  m_sticky, m_lvl, m_s1;
    logic        m_rdy, m_tick, m_vs_prev;
    logic [31:0] m_rd;
`ifdef PONG_BTN_DEBOUNCE_EN
    logic [3:0]  m_s2;
    int          m_cnt [4];
`endif

    pong_pos_regfile #(
        .PADDLE_INIT(150), .BALL_INIT_X(320), .BALL_INIT_Y(240), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .vsync(vsync), .btn(btn),
        .paddle_left_pos(paddle_left_pos), .paddle_right_pos(paddle_right_pos),
        .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_sh[0] = 10'd150; m_sh[1] = 10'd150; m_sh[2] = 10'd320; m_sh[3] = 10'd240;
        m_act = m_sh;
        m_pend = 1'b0; m_fc = '0; m_sticky = '0; m_lvl = '0; m_s1 = '0;
        m_rdy = 1'b0; m_tick = 1'b0; m_vs_prev = 1'b0; m_rd = '0;
`ifdef PONG_BTN_DEBOUNCE_EN
        m_s2 = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
    endtask

    // Advance one clock, applying the block's rules to the model from the inputs driven now.
    task automatic step();
        logic [7:0]  pg;
        int          n;
        bit          acc, fall, wr;
        logic [31:0] rd;
        logic [3:0]  lvl_n, rise;
        pg   = iomem_addr[31:24];
        n    = int'(iomem_addr[25:24]);
        acc  = iomem_valid && !m_rdy && pg >= 8'h04 && pg <= 8'h0C;
        fall = m_vs_prev && !vsync;
        rd   = '0;
        if (acc) begin
            if (pg <= 8'h07)      rd = {22'd0, m_sh[n]};
            else if (pg <= 8'h0B) rd = {30'd0, m_sticky[n], m_lvl[n]};
            else                  rd = {m_fc, 15'd0, m_pend};
        end
        if (fall) begin
            m_fc = m_fc + 16'd1;
            if (m_pend) begin m_act = m_sh; m_pend = 1'b0; end
        end
        wr = acc && pg <= 8'h07 && iomem_wstrb[1:0] != 2'b00;
        if (wr) begin
            if (iomem_wstrb[0]) m_sh[n][7:0] = iomem_wdata[7:0];
            if (iomem_wstrb[1]) m_sh[n][9:8] = iomem_wdata[9:8];
            m_pend = 1'b1;
        end
        lvl_n = m_lvl;
`ifdef PONG_BTN_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_lvl[i]) m_cnt[i] = 0;
            else if (m_cnt[i] + 1 == DB) begin lvl_n[i] = m_s2[i]; m_cnt[i] = 0; end
            else m_cnt[i] = m_cnt[i] + 1;
        end
        m_s2 = m_s1;
`else
        lvl_n = m_s1;
`endif
        m_s1 = btn;
        rise = lvl_n & ~m_lvl;
        if (acc && pg >= 8'h08 && pg <= 8'h0B && iomem_wstrb == 4'd0) m_sticky[n] = 1'b0;
        m_sticky = m_sticky | rise;
        m_lvl = lvl_n;
        m_rdy = acc; m_rd = rd; m_tick = fall; m_vs_prev = vsync;
        @(posedge clk); #1;
    endtask

    task automatic idle_bus();
        iomem_valid = 1'b0; iomem_addr = '0; iomem_wstrb = '0; iomem_wdata = '0;
    endtask

    // One transfer: returns ready/rdata in the cycle after valid, plus the model's expected rdata.
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic rdy, output logic [31:0] rd, output logic [31:0] exp_rd);
        iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
        step();
        rdy = iomem_ready; rd = iomem_rdata; exp_rd = m_rd;
        idle_bus();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1; idle_bus(); vsync = 1'b1; btn = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        logic rdy; logic [31:0] rd, er;
        do_reset();
        cmp++; if ({paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y} !== {10'd150, 10'd150, 10'd320, 10'd240}) begin
            errs++; $display("FAIL reset_pos: got %0d/%0d/%0d/%0d want 150/150/320/240", paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y); end
        cmp++; if ({iomem_ready, iomem_rdata, frame_tick} !== 34'd0) begin
            errs++; $display("FAIL reset_bus: ready %b rdata %h tick %b want 0", iomem_ready, iomem_rdata, frame_tick); end
        bus(32'h0400_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rdy !== 1'b1 || rd !== 32'd150) begin
            errs++; $display("FAIL rd_left: ready %b rdata %0d want 1/150", rdy, rd); end
        cmp++; if (iomem_ready !== 1'b0 || iomem_rdata !== 32'd0) begin
            errs++; $display("FAIL ready_pulse: ready %b rdata %h want 0/0", iomem_ready, iomem_rdata); end
        bus(32'h0600_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'd320) begin errs++; $display("FAIL rd_ballx: got %0d want 320", rd); end
        bus(32'h0C00_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rdy !== 1'b1 || rd !== 32'd0) begin errs++; $display("FAIL rd_status0: ready %b rdata %h want 1/0", rdy, rd); end
    endtask

    task automatic test_commit();
        logic rdy; logic [31:0] rd, er;
        bus(32'h0400_0000, 4'b0011, 32'h0000_03FF, rdy, rd, er);
        cmp++; if (paddle_left_pos !== 10'd150) begin errs++; $display("FAIL no_early_commit: got %0d want 150", paddle_left_pos); end
        bus(32'h0400_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'h3FF) begin errs++; $display("FAIL shadow_left: got %h want 3ff", rd); end
        bus(32'h0C00_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'h1) begin errs++; $display("FAIL pending_set: got %h want 1", rd); end
        vsync = 1'b0; step();
        cmp++; if (paddle_left_pos !== 10'h3FF || frame_tick !== 1'b1) begin
            errs++; $display("FAIL commit: pos %h tick %b want 3ff/1", paddle_left_pos, frame_tick); end
        step();
        cmp++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL tick_width: got %b want 0", frame_tick); end
        vsync = 1'b1;
        bus(32'h0C00_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'h0001_0000) begin errs++; $display("FAIL status_after: got %h want 00010000", rd); end
    endtask

    task automatic test_strobe();
        logic rdy; logic [31:0] rd, er;
        bus(32'h0600_0000, 4'b0001, 32'h0000_01AB, rdy, rd, er);
        bus(32'h0600_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'h1AB) begin errs++; $display("FAIL strobe_lo: got %h want 1ab", rd); end
        bus(32'h0600_0000, 4'b0010, 32'h0000_0200, rdy, rd, er);
        vsync = 1'b0; step(); vsync = 1'b1; step();
        cmp++; if (ball_pos_x !== 10'h2AB) begin errs++; $display("FAIL strobe_hi: got %h want 2ab", ball_pos_x); end
    endtask

    task automatic test_collision();
        logic rdy; logic [31:0] rd, er;
        bus(32'h0600_0000, 4'b0011, 32'h0000_0155, rdy, rd, er);
        vsync = 1'b0;
        bus(32'h0700_0000, 4'b0011, 32'd100, rdy, rd, er);
        cmp++; if (ball_pos_x !== 10'h155 || ball_pos_y !== 10'd240) begin
            errs++; $display("FAIL collide_commit: x %h y %0d want 155/240", ball_pos_x, ball_pos_y); end
        vsync = 1'b1;
        bus(32'h0C00_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd[0] !== 1'b1) begin errs++; $display("FAIL collide_pending: got %b want 1", rd[0]); end
        vsync = 1'b0; step(); vsync = 1'b1; step();
        cmp++; if (ball_pos_y !== 10'd100) begin errs++; $display("FAIL collide_next: got %0d want 100", ball_pos_y); end
    endtask

    task automatic test_buttons();
        logic rdy; logic [31:0] rd, er;
        btn = 4'b0100;
        repeat (BTN_WAIT) step();
        bus(32'h0A00_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'h3) begin errs++; $display("FAIL btn_press: got %h want 3", rd); end
        bus(32'h0A00_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'h1) begin errs++; $display("FAIL btn_sticky_clr: got %h want 1", rd); end
        btn = 4'b0000;
        repeat (BTN_WAIT) step();
        bus(32'h0A00_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'h0) begin errs++; $display("FAIL btn_release: got %h want 0", rd); end
    endtask

    task automatic test_unclaimed();
        int seen = 0;
        iomem_valid = 1'b1; iomem_addr = 32'h0D00_0000; iomem_wstrb = 4'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (iomem_ready !== 1'b0) seen++;
        end
        idle_bus(); step();
        cmp++; if (seen !== 0) begin errs++; $display("FAIL unclaimed: ready seen %0d cycles want 0", seen); end
    endtask

    task automatic test_reset_mid();
        logic rdy; logic [31:0] rd, er;
        iomem_valid = 1'b1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'b0011; iomem_wdata = 32'h2A;
        #2 reset = 1'b1;
        #1;
        cmp++; if (iomem_ready !== 1'b0) begin errs++; $display("FAIL reset_mid_ready: got %b want 0", iomem_ready); end
        @(posedge clk); #1;
        cmp++; if (iomem_ready !== 1'b0) begin errs++; $display("FAIL reset_hold_ready: got %b want 0", iomem_ready); end
        idle_bus(); vsync = 1'b1; btn = '0; model_reset();
        reset = 1'b0;
        step();
        bus(32'h0400_0000, 4'd0, 32'd0, rdy, rd, er);
        cmp++; if (rd !== 32'd150 || paddle_left_pos !== 10'd150) begin
            errs++; $display("FAIL reset_mid_shadow: rd %0d pos %0d want 150/150", rd, paddle_left_pos); end
    endtask

    task automatic test_random();
        logic [7:0] pages [12] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'hFF};
        for (int c = 0; c < 600; c++) begin
            iomem_valid = ($urandom_range(0, 2) != 0);
            iomem_addr  = {pages[$urandom_range(0, 11)], 24'($urandom)};
            iomem_wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            iomem_wdata = $urandom;
            if ($urandom_range(0, 7) == 0) vsync = ~vsync;
            if ($urandom_range(0, 15) == 0) btn[$urandom_range(0, 3)] = ~btn[$urandom_range(0, 3)];
            step();
            cmp++; if ({paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y} !== {m_act[0], m_act[1], m_act[2], m_act[3]}) begin
                errs++; $display("FAIL rand_pos c%0d: got %h/%h/%h/%h want %h/%h/%h/%h", c, paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y, m_act[0], m_act[1], m_act[2], m_act[3]); end
            cmp++; if (iomem_ready !== m_rdy || iomem_rdata !== m_rd) begin
                errs++; $display("FAIL rand_bus c%0d: ready %b rdata %h want %b/%h", c, iomem_ready, iomem_rdata, m_rdy, m_rd); end
            cmp++; if (frame_tick !== m_tick) begin
                errs++; $display("FAIL rand_tick c%0d: got %b want %b", c, frame_tick, m_tick); end
        end
        idle_bus(); step();
    endtask

    initial begin
        test_reset();
        test_commit();
        test_strobe();
        test_collision();
        test_buttons();
        test_unclaimed();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
